// File: rtl/decoder_phase_sequencer.sv
// Sequencing end of the decoder interface: phase counter XPT, instruction register
// ITABLE, one-hot cycle mode and multi-cycle flags. Optional retired-opcode counter: DECODER_SEQ_ICOUNT_EN.
module decoder_phase_sequencer #(
  parameter int XPT_MAX      = 15,
  parameter int FETCH_PHASE  = 1,
  parameter int ACCESS_PHASE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  op_data,
  input  logic        mem_ready,
  input  logic        PR_Reset_XPT,
  input  logic        P2_Set_CM1,
  input  logic        P2_Set_CMR,
  input  logic        P2_Set_CMA,
  input  logic        P2_Reset_ITABLE,
  input  logic        P2_Set_ILDlnnlHL_1,
  input  logic        P2_Set_ILDAlnnl_1,
  input  logic        P2_Set_IJPnn_1,
  output logic        enable,
  output logic [3:0]  XPT,
  output logic [3:0]  notXPT,
  output logic [7:0]  ITABLE,
  output logic [7:0]  notITABLE,
  output logic        CM1,
  output logic        CMR,
  output logic        CMA,
  output logic        ILDlnnlHL_1,
  output logic        ILDAlnnl_1,
  output logic        IJPnn_1,
  output logic        xpt_overrun,
  output logic [15:0] icount
);

  localparam logic [3:0] LP_XPT_MAX = 4'(XPT_MAX);
  localparam logic [3:0] LP_FETCH   = 4'(FETCH_PHASE);
  localparam logic [3:0] LP_ACCESS  = 4'(ACCESS_PHASE);

  // One-hot encoding doubles as the visible mode outputs {CMA, CMR, CM1}.
  typedef enum logic [2:0] {
    MODE_CM1 = 3'b001,
    MODE_CMR = 3'b010,
    MODE_CMA = 3'b100
  } mode_e;

  mode_e       r_mode;
  mode_e       w_mode_next;
  logic        r_running;
  logic [3:0]  r_xpt;
  logic [7:0]  r_itable;
  logic        r_overrun;
  logic        r_ildnnhl, r_ildann, r_ijpnn;
  logic        w_stall;
  logic        w_load;

  assign w_stall = (r_mode == MODE_CM1 || r_mode == MODE_CMR) &&
                   (r_xpt == LP_ACCESS) && !mem_ready;
  assign w_load  = (r_mode == MODE_CM1) && (r_itable == 8'h00) &&
                   (r_xpt == LP_FETCH) && mem_ready && r_running;

  always_ff @(posedge clock) begin
    if (reset) r_mode <= MODE_CM1;
    else       r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = r_mode;
    if (P2_Set_CM1)      w_mode_next = MODE_CM1;
    else if (P2_Set_CMR) w_mode_next = MODE_CMR;
    else if (P2_Set_CMA) w_mode_next = MODE_CMA;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_running <= 1'b0;
      r_xpt     <= 4'd0;
      r_overrun <= 1'b0;
      r_itable  <= 8'h00;
      r_ildnnhl <= 1'b0;
      r_ildann  <= 1'b0;
      r_ijpnn   <= 1'b0;
    end else begin
      r_running <= 1'b1;
      if (PR_Reset_XPT)            r_xpt <= 4'd0;
      else if (w_stall)            r_xpt <= r_xpt;
      else if (r_xpt == LP_XPT_MAX) r_overrun <= 1'b1;
      else                         r_xpt <= r_xpt + 4'd1;

      if (P2_Reset_ITABLE) r_itable <= 8'h00;
      else if (w_load)     r_itable <= op_data;

      // A flag's own set strobe beats the clear carried by P2_Set_CM1.
      if (P2_Set_ILDlnnlHL_1) r_ildnnhl <= 1'b1;
      else if (P2_Set_CM1)    r_ildnnhl <= 1'b0;
      if (P2_Set_ILDAlnnl_1)  r_ildann  <= 1'b1;
      else if (P2_Set_CM1)    r_ildann  <= 1'b0;
      if (P2_Set_IJPnn_1)     r_ijpnn   <= 1'b1;
      else if (P2_Set_CM1)    r_ijpnn   <= 1'b0;
    end
  end

`ifdef DECODER_SEQ_ICOUNT_EN
  logic [15:0] r_icount;
  always_ff @(posedge clock) begin
    if (reset)                          r_icount <= 16'h0000;
    else if (w_load && !P2_Reset_ITABLE) r_icount <= r_icount + 16'h0001;
  end
  assign icount = r_icount;
`else
  assign icount = 16'h0000;
`endif

  assign enable      = r_running && !w_stall;
  assign XPT         = r_xpt;
  assign notXPT      = ~r_xpt;
  assign ITABLE      = r_itable;
  assign notITABLE   = ~r_itable;
  assign {CMA, CMR, CM1} = r_mode;
  assign ILDlnnlHL_1 = r_ildnnhl;
  assign ILDAlnnl_1  = r_ildann;
  assign IJPnn_1     = r_ijpnn;
  assign xpt_overrun = r_overrun;

endmodule

// File: tb/tb_decoder_phase_sequencer.sv
// Bench for decoder_phase_sequencer: directed plan steps followed by random traffic,
// every output compared each cycle against a behavioural model.
module tb_decoder_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  op_data;
  logic        mem_ready, PR_Reset_XPT, P2_Set_CM1, P2_Set_CMR, P2_Set_CMA;
  logic        P2_Reset_ITABLE, P2_Set_ILDlnnlHL_1, P2_Set_ILDAlnnl_1, P2_Set_IJPnn_1;
  logic        enable, CM1, CMR, CMA, ILDlnnlHL_1, ILDAlnnl_1, IJPnn_1, xpt_overrun;
  logic [3:0]  XPT, notXPT;
  logic [7:0]  ITABLE, notITABLE;
  logic [15:0] icount;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: mode 0=CM1 1=CMR 2=CMA; flags[0..2] = ILDlnnlHL, ILDAlnnl, IJPnn.
  int m_xpt, m_itable, m_mode, m_icount;
  bit m_running, m_overrun;
  bit m_flags[3];

  decoder_phase_sequencer dut (
    .clock(clock), .reset(reset), .op_data(op_data), .mem_ready(mem_ready),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .P2_Set_CMA(P2_Set_CMA), .P2_Reset_ITABLE(P2_Reset_ITABLE),
    .P2_Set_ILDlnnlHL_1(P2_Set_ILDlnnlHL_1), .P2_Set_ILDAlnnl_1(P2_Set_ILDAlnnl_1),
    .P2_Set_IJPnn_1(P2_Set_IJPnn_1), .enable(enable), .XPT(XPT), .notXPT(notXPT),
    .ITABLE(ITABLE), .notITABLE(notITABLE), .CM1(CM1), .CMR(CMR), .CMA(CMA),
    .ILDlnnlHL_1(ILDlnnlHL_1), .ILDAlnnl_1(ILDAlnnl_1), .IJPnn_1(IJPnn_1),
    .xpt_overrun(xpt_overrun), .icount(icount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    return (m_mode != 2) && (m_xpt == 1) && !mem_ready;
  endfunction

  task automatic check_all();
    chk("enable",      16'(enable),      16'(m_running && !model_stall()));
    chk("XPT",         16'(XPT),         16'(m_xpt));
    chk("notXPT",      16'(notXPT),      16'(15 - m_xpt));
    chk("ITABLE",      16'(ITABLE),      16'(m_itable));
    chk("notITABLE",   16'(notITABLE),   16'(255 - m_itable));
    chk("mode",        16'({CMA, CMR, CM1}), 16'(1 << m_mode));
    chk("ILDlnnlHL_1", 16'(ILDlnnlHL_1), 16'(m_flags[0]));
    chk("ILDAlnnl_1",  16'(ILDAlnnl_1),  16'(m_flags[1]));
    chk("IJPnn_1",     16'(IJPnn_1),     16'(m_flags[2]));
    chk("xpt_overrun", 16'(xpt_overrun), 16'(m_overrun));
    chk("icount",      16'(icount),      16'(m_icount));
  endtask

  task automatic model_edge();
    bit strobes[3];
    bit stall, load;
    strobes = '{P2_Set_ILDlnnlHL_1, P2_Set_ILDAlnnl_1, P2_Set_IJPnn_1};
    if (reset) begin
      m_xpt = 0; m_itable = 0; m_mode = 0; m_icount = 0;
      m_running = 0; m_overrun = 0; m_flags = '{0, 0, 0};
      return;
    end
    stall = model_stall();
    load  = (m_mode == 0) && (m_itable == 0) && (m_xpt == 1) && mem_ready && m_running;
    if (P2_Reset_ITABLE) m_itable = 0;
    else if (load) begin
      m_itable = int'(op_data);
`ifdef DECODER_SEQ_ICOUNT_EN
      m_icount = (m_icount + 1) % 65536;
`endif
    end
    if (PR_Reset_XPT) m_xpt = 0;
    else if (!stall) begin
      if (m_xpt == 15) m_overrun = 1;
      m_xpt = (m_xpt + 1 > 15) ? 15 : m_xpt + 1;
    end
    if (P2_Set_CM1) m_mode = 0;
    else if (P2_Set_CMR) m_mode = 1;
    else if (P2_Set_CMA) m_mode = 2;
    for (int k = 0; k < 3; k++)
      m_flags[k] = strobes[k] | (m_flags[k] & !P2_Set_CM1);
    m_running = 1;
  endtask

  task automatic cycle();
    #1;
    check_all();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Set_CMR = 0; P2_Set_CMA = 0;
    P2_Reset_ITABLE = 0; P2_Set_ILDlnnlHL_1 = 0; P2_Set_ILDAlnnl_1 = 0; P2_Set_IJPnn_1 = 0;
  endtask

  initial begin
    idle(); reset = 1; op_data = 8'h00; mem_ready = 0;
    m_xpt = 0; m_itable = 0; m_mode = 0; m_icount = 0;
    m_running = 0; m_overrun = 0; m_flags = '{0, 0, 0};
    @(posedge clock); #1;
    model_edge();

    // Reset held three cycles.
    repeat (3) cycle();
    reset = 0; mem_ready = 1; op_data = 8'h3A;
    #1;
    chk("rst_xpt", 16'(XPT), 16'h0);
    chk("rst_notitable", 16'(notITABLE), 16'h00FF);
    chk("rst_cm1", 16'(CM1), 16'h1);
    chk("rst_enable_first", 16'(enable), 16'h0);

    // Opcode fetch.
    cycle();
    chk("fetch_enable", 16'(enable), 16'h1);
    chk("fetch_xpt1", 16'(XPT), 16'h1);
    cycle();
    chk("fetch_itable", 16'(ITABLE), 16'h003A);
    chk("fetch_notitable", 16'(notITABLE), 16'h00C5);
    chk("fetch_xpt2", 16'(XPT), 16'h2);
`ifdef DECODER_SEQ_ICOUNT_EN
    chk("fetch_icount", icount, 16'h1);
`endif

    // Stall in CMR at the access phase.
    P2_Set_CMR = 1; PR_Reset_XPT = 1; cycle(); idle();
    cycle();
    mem_ready = 0;
    repeat (4) begin
      cycle();
      chk("stall_xpt", 16'(XPT), 16'h1);
      chk("stall_enable", 16'(enable), 16'h0);
    end
    mem_ready = 1; cycle();
    chk("stall_release_xpt", 16'(XPT), 16'h2);

    // Mode strobe priority.
    P2_Set_CMR = 1; P2_Set_CMA = 1; cycle(); idle();
    chk("prio_cmr", 16'({CMA, CMR, CM1}), 16'h2);
    P2_Set_CM1 = 1; P2_Set_CMR = 1; cycle(); idle();
    chk("prio_cm1", 16'({CMA, CMR, CM1}), 16'h1);

    // Multi-cycle flag set/hold/clear.
    P2_Set_IJPnn_1 = 1; cycle(); idle();
    cycle();
    chk("ijp_hold", 16'(IJPnn_1), 16'h1);
    P2_Set_CM1 = 1; P2_Set_IJPnn_1 = 1; cycle(); idle();
    chk("ijp_set_wins", 16'(IJPnn_1), 16'h1);
    P2_Set_CM1 = 1; cycle(); idle();
    chk("ijp_cleared", 16'(IJPnn_1), 16'h0);

    // Saturation and sticky overrun.
    PR_Reset_XPT = 1; cycle(); idle();
    repeat (20) cycle();
    chk("ovr_xpt", 16'(XPT), 16'hF);
    chk("ovr_flag", 16'(xpt_overrun), 16'h1);
    PR_Reset_XPT = 1; cycle(); idle();
    chk("ovr_xpt_cleared", 16'(XPT), 16'h0);
    chk("ovr_sticky", 16'(xpt_overrun), 16'h1);
    reset = 1; cycle(); idle();
    chk("ovr_reset", 16'(xpt_overrun), 16'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 59) == 0);
      PR_Reset_XPT       = ($urandom_range(0, 5) == 0);
      P2_Set_CM1         = ($urandom_range(0, 7) == 0);
      P2_Set_CMR         = ($urandom_range(0, 7) == 0);
      P2_Set_CMA         = ($urandom_range(0, 7) == 0);
      P2_Reset_ITABLE    = ($urandom_range(0, 9) == 0);
      P2_Set_ILDlnnlHL_1 = ($urandom_range(0, 9) == 0);
      P2_Set_ILDAlnnl_1  = ($urandom_range(0, 9) == 0);
      P2_Set_IJPnn_1     = ($urandom_range(0, 9) == 0);
      mem_ready          = ($urandom_range(0, 3) != 0);
      op_data            = 8'($urandom_range(0, 255));
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_phase_sequencer.md
Name: decoder_phase_sequencer

Overview:
Sequencing end of the instruction-decoder interface. Owns the phase counter XPT, the instruction register ITABLE and the cycle-mode and multi-cycle flags. It drives these, with their complements, into the decoder tree and consumes the decoder's P2_/PR_ strobes on the next clock edge. It sits between the memory/opcode bus and the top decoder instance.

Parameters:
XPT_MAX, 15, highest legal phase value; XPT saturates here.
FETCH_PHASE, 1, XPT value at which the opcode is latched during CM1.
ACCESS_PHASE, 1, XPT value at which mem_ready is honoured in CM1/CMR.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
op_data  in  8  opcode/data byte from the memory bus
mem_ready  in  1  memory access complete
PR_Reset_XPT  in  1  clear phase counter
P2_Set_CM1  in  1  enter opcode-fetch mode
P2_Set_CMR  in  1  enter memory-read mode
P2_Set_CMA  in  1  enter address-only mode
P2_Reset_ITABLE  in  1  clear instruction register
P2_Set_ILDlnnlHL_1  in  1  set LD (nn),HL second-stage flag
P2_Set_ILDAlnnl_1  in  1  set LD A,(nn) second-stage flag
P2_Set_IJPnn_1  in  1  set JP nn second-stage flag
enable  out  1  decoder enable
XPT  out  4  phase counter
notXPT  out  4  bitwise complement of XPT
ITABLE  out  8  instruction register
notITABLE  out  8  bitwise complement of ITABLE
CM1, CMR, CMA  out  1 each  one-hot cycle mode
ILDlnnlHL_1, ILDAlnnl_1, IJPnn_1  out  1 each  second-stage flags
xpt_overrun  out  1  sticky: XPT held at XPT_MAX without a reset strobe
icount  out  16  retired-opcode count (feature only)

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high.
- Reset values: XPT=0, ITABLE=0x00, CM1=1, CMR=0, CMA=0, all _1 flags 0, xpt_overrun=0, icount=0. enable is 0 during reset and for the first cycle after reset deasserts.
- notXPT is always ~XPT and notITABLE is always ~ITABLE, both combinational. They are never stale.
- stall = (CM1|CMR) & (XPT==ACCESS_PHASE) & ~mem_ready.
- enable = running & ~stall. running is a register that goes to 1 one cycle after reset.
- XPT update priority, per edge:
  - reset.
  - Else if PR_Reset_XPT: XPT=0.
  - Else if stall: hold.
  - Else if XPT==XPT_MAX: hold, and set xpt_overrun.
  - Else: XPT+1.
- xpt_overrun clears only on reset.
- Cycle-mode update: applies only when some P2_Set_CMx is high.
  - Next mode is one-hot, priority CM1 > CMR > CMA.
  - With no set strobe, the mode holds.
  - CM1, CMR and CMA are never simultaneously high and never all low.
- ITABLE update priority:
  - reset.
  - Else if P2_Reset_ITABLE: ITABLE=0x00.
  - Else if CM1 & (ITABLE==0x00) & (XPT==FETCH_PHASE) & mem_ready & running: ITABLE=op_data (opcode load).
  - Else: hold.
- A reset strobe and a load condition on the same edge: reset wins. The load occurs on a later qualifying edge.
- Each _1 flag:
  - Set by its strobe.
  - Cleared by P2_Set_CM1 when its own strobe is low.
  - Set wins when both are high on the same edge.
  - Otherwise holds.
- Strobes are sampled on every edge, including while stalled.
- Stall freezes only XPT and the opcode load.
- Reset mid-instruction discards all state. There is no partial-instruction recovery.

Optional Feature:
DECODER_SEQ_ICOUNT_EN.
- Defined: icount increments by 1 on every opcode-load edge and wraps 0xFFFF->0x0000. It clears on reset.
- Undefined: icount is tied to 16'h0000 and no counter flops exist.

Test Plan:
- Reset: hold reset 3 cycles, then release -> XPT=0, ITABLE=0x00, notITABLE=0xFF, CM1=1, enable=0 for 1 cycle then 1.
- Fetch: mem_ready=1, op_data=0x3A -> at XPT=1 edge ITABLE=0x3A, notITABLE=0xC5. The next edge gives XPT=2. With the feature, icount=1.
- Stall: mem_ready=0 at XPT=1 in CMR for 4 cycles -> XPT stays 1, enable=0. mem_ready=1 -> XPT=2 on the next edge.
- Strobe priority: P2_Set_CMR and P2_Set_CMA together -> CMR=1, CMA=0. Then P2_Set_CM1 with P2_Set_CMR -> CM1=1.
- Multi-cycle: P2_Set_IJPnn_1 pulse -> IJPnn_1=1 holds. P2_Set_CM1 together with P2_Set_IJPnn_1 -> IJPnn_1 stays 1. P2_Set_CM1 alone -> IJPnn_1=0.
- Overrun/reset: 20 cycles with no PR_Reset_XPT -> XPT=15, xpt_overrun=1. Then PR_Reset_XPT -> XPT=0, xpt_overrun stays 1 until reset.
